// File: rtl/mem_responder.sv
// mem_responder: word-addressed 16-bit memory target with a fixed-latency read pipeline.
//
// Accepts one request per cycle. Writes update storage at the acceptance edge and produce no
// response. Single reads return one beat LATENCY cycles after acceptance. Burst reads return an
// aligned 8-word line, one beat per cycle. The request port stalls while the line is being
// issued.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset (storage is not cleared)
//   req_valid  request present            req_ready  request can be accepted this cycle
//   req_wr     1 = write, 0 = read        req_burst  8-beat line read (ignored for writes)
//   req_addr   byte address (bit 0 ignored)
//   req_wdata  write data
//   rsp_valid  read beat valid (no back-pressure)
//   rsp_data   read beat data             rsp_addr   byte address of returned word
//   rsp_last   final beat of the read
// All rsp_* outputs are zero whenever rsp_valid is low.

module mem_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_burst,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [15:0] rsp_addr,
  output logic        rsp_last
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  // ---------------------------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic [11:0] line_q, line_d;

  logic accept;
  logic wr_en;
  logic rd_single;
  logic rd_burst_start;

  // Ready is a pure function of the FSM, so a stalled initiator sees it drop for the whole line.
  assign req_ready      = (state_q == StIdle) & ~rst;
  assign accept         = req_valid & req_ready;
  assign wr_en          = accept & req_wr;
  assign rd_single      = accept & ~req_wr & ~req_burst;
  assign rd_burst_start = accept & ~req_wr & req_burst;

  // Byte-lane bit of the address carries no information for word accesses.
  logic unused_addr_lsb;
  assign unused_addr_lsb = req_addr[0];

  // ---------------------------------------------------------------------------------------------
  // Read issue: one internal read per cycle, either a single read or the next line beat
  // ---------------------------------------------------------------------------------------------
  logic        issue_valid;
  logic [15:0] issue_addr;
  logic        issue_last;

  always_comb begin
    issue_valid = 1'b0;
    issue_addr  = 16'h0000;
    issue_last  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_single) begin
          issue_valid = 1'b1;
          issue_addr  = {req_addr[15:1], 1'b0};
          issue_last  = 1'b1;
        end else if (rd_burst_start) begin
          issue_valid = 1'b1;
          issue_addr  = {req_addr[15:4], 4'h0};
          issue_last  = 1'b0;
        end
      end
      StBurst: begin
        // Beat offset lives in bits [3:1] only, so the line wraps with no carry into bit 4.
        issue_valid = 1'b1;
        issue_addr  = {line_q, beat_q, 1'b0};
        issue_last  = (beat_q == 3'd7);
      end
      default: begin
        issue_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Burst FSM
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    unique case (state_q)
      StIdle: begin
        if (rd_burst_start) begin
          state_d = StBurst;
          beat_d  = 3'd1;
          line_d  = req_addr[15:4];
        end
      end
      StBurst: begin
        if (beat_q == 3'd7) begin
          state_d = StIdle;
          beat_d  = 3'd0;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      default: begin
        state_d = StIdle;
        beat_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= 3'd0;
      line_q  <= 12'h000;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Storage: no reset so contents survive rst
  // ---------------------------------------------------------------------------------------------
  logic [15:0]           mem_q [Words];
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [15:0]           rd_data;

  // Upper address bits fall outside the index and alias onto the same words.
  assign wr_idx  = req_addr[DEPTH_LOG2:1];
  assign rd_idx  = issue_addr[DEPTH_LOG2:1];
  assign rd_data = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= req_wdata;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Latency pipeline: stage 0 captures the read at the issue edge, stage LATENCY-1 drives rsp_*.
  // Invalid stages carry zeros so the outputs come straight from flops with no gating.
  // ---------------------------------------------------------------------------------------------
  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [LATENCY-1:0] pipe_last_q, pipe_last_d;
  logic [15:0]        pipe_data_q [LATENCY];
  logic [15:0]        pipe_data_d [LATENCY];
  logic [15:0]        pipe_addr_q [LATENCY];
  logic [15:0]        pipe_addr_d [LATENCY];

  always_comb begin
    pipe_vld_d     = '0;
    pipe_last_d    = '0;
    pipe_vld_d[0]  = issue_valid;
    pipe_last_d[0] = issue_valid & issue_last;
    pipe_data_d[0] = issue_valid ? rd_data : 16'h0000;
    pipe_addr_d[0] = issue_valid ? issue_addr : 16'h0000;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data_q[i] <= 16'h0000;
        pipe_addr_q[i] <= 16'h0000;
      end
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data_q[i] <= pipe_data_d[i];
        pipe_addr_q[i] <= pipe_addr_d[i];
      end
    end
  end

  assign rsp_valid = pipe_vld_q[LATENCY-1];
  assign rsp_last  = pipe_last_q[LATENCY-1];
  assign rsp_data  = pipe_data_q[LATENCY-1];
  assign rsp_addr  = pipe_addr_q[LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: table of single requests plus hand-written burst, stall and
// mid-burst reset sequences. Read expectations are queued at acceptance and checked on output.

module tb_mem_responder;

  localparam int unsigned L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic        req_burst = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] rsp_addr;
  logic        rsp_last;

  mem_responder #(
    .LATENCY   (L),
    .DEPTH_LOG2(15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr   (req_wr),
    .req_burst(req_burst),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_addr (rsp_addr),
    .rsp_last (rsp_last)
  );

  always #5 clk = ~clk;

  // Cycle n is the interval after the n-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [15:0] addr;
    logic        last;
  } exp_t;

  typedef struct {
    bit          wr;
    bit          burst;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  exp_t        sb[$];
  logic [15:0] model[int];
  int          n_tests = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: every cycle either a queued beat is due or all rsp_* must be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got rsp_valid=1 addr %h at cycle %0d, required none",
                   rsp_addr, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("beat_cycle", cyc, e.cyc);
          chk("beat_data", {16'h0, rsp_data}, {16'h0, e.data});
          chk("beat_addr", {16'h0, rsp_addr}, {16'h0, e.addr});
          chk("beat_last", {31'h0, rsp_last}, {31'h0, e.last});
        end
      end else begin
        chk("idle_data_addr", {rsp_data, rsp_addr}, 32'h0);
        chk("idle_valid_last", {30'h0, rsp_valid, rsp_last}, 32'h0);
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL missing_beat: got no beat at cycle %0d, required addr %h due cycle %0d",
                   cyc, sb[0].addr, sb[0].cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Drive one request, hold it until accepted, and queue the responses it must produce.
  task automatic do_req(input bit wr, input bit burst, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp, output int acc);
    int   waited;
    logic [15:0] a;
    logic [2:0]  kb;
    waited    = 0;
    acc       = -1;
    req_valid = 1'b1;
    req_wr    = wr;
    req_burst = burst;
    req_addr  = addr;
    req_wdata = wdata;
    forever begin
      @(negedge clk);
      if (req_ready === 1'b1) break;
      waited++;
      if (waited > 40) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got no acceptance of addr %h, required within 40", addr);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (waited <= 40) begin
      acc = cyc;
      if (wr) begin
        model[int'(addr[15:1])] = wdata;
      end else if (!burst) begin
        sb.push_back('{acc + L, exp, {addr[15:1], 1'b0}, 1'b1});
      end else begin
        for (int k = 0; k < 8; k++) begin
          kb = 3'(k);
          a  = {addr[15:4], kb, 1'b0};
          sb.push_back('{acc + L + k, model[int'(a[15:1])], a, (k == 7)});
        end
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_burst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   acc, prev, t;

    // Write 0x1234 then read it the very next cycle.
    vecs.push_back('{1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0000});
    vecs.push_back('{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234});
    vecs.push_back('{1'b1, 1'b0, 16'h0000, 16'h000A, 16'h0000});
    vecs.push_back('{1'b1, 1'b0, 16'h0002, 16'h000B, 16'h0000});
    vecs.push_back('{1'b1, 1'b0, 16'h0004, 16'h000C, 16'h0000});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h000A});
    vecs.push_back('{1'b0, 1'b0, 16'h0002, 16'h0000, 16'h000B});
    vecs.push_back('{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h000C});
    // Odd byte address reads the containing word.
    vecs.push_back('{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h1234});
    // 0x10002 aliases onto 0x0002 with a 16-bit address and DEPTH_LOG2=15.
    vecs.push_back('{1'b1, 1'b0, 16'h0002, 16'hBEEF, 16'h0000});
    vecs.push_back('{1'b0, 1'b0, 16'(17'h1_0002), 16'h0000, 16'hBEEF});
    vecs.push_back('{1'b1, 1'b0, 16'hFFFE, 16'h5A5A, 16'h0000});
    vecs.push_back('{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h5A5A});
    // Burst flag on a write must not stall the port.
    vecs.push_back('{1'b1, 1'b1, 16'h0020, 16'h7777, 16'h0000});
    vecs.push_back('{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h7777});
    for (int k = 0; k < 8; k++) begin
      vecs.push_back('{1'b1, 1'b0, 16'(16'h0040 + 2 * k), 16'(16'h0100 + k), 16'h0000});
    end

    // Reset behaviour.
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("ready_during_reset", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Table: one request per cycle, never stalled.
    prev = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].wr, vecs[i].burst, vecs[i].addr, vecs[i].wdata, vecs[i].exp, acc);
      if (i > 0) chk("back_to_back_accept", acc, prev + 1);
      prev = acc;
    end
    idle(L + 2);

    // Burst at 0x0046: ready low for 7 cycles, line 0x0040..0x004E returned.
    do_req(1'b0, 1'b1, 16'h0046, 16'h0000, 16'h0000, t);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("burst_ready", {31'h0, req_ready}, {31'h0, (i == 8)});
      @(posedge clk);
      #1;
    end
    idle(L + 4);

    // Request held through a burst is accepted when ready returns.
    do_req(1'b0, 1'b1, 16'h004E, 16'h0000, 16'h0000, t);
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, acc);
    chk("held_accept_cycle", acc, t + 8);
    idle(L + 4);

    // Reset in cycle T+6 of a burst drops the remaining beats.
    do_req(1'b0, 1'b1, 16'h0040, 16'h0000, 16'h0000, t);
    idle(5);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_in_mid_reset", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("ready_after_mid_reset", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    idle(12);
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, acc);
    do_req(1'b0, 1'b0, 16'h0046, 16'h0000, 16'h0103, acc);
    idle(L + 4);
    chk("scoreboard_drained", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to first read response beat; legal range 1..8.
REQ-002 SHALL have parameter DEPTH_LOG2, default 15, meaning log2 of 16-bit word count in storage.
REQ-003 SHALL have a single clock and a synchronous active-high reset named rst: clk  in  1  rising-edge clock for all state.
REQ-004 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have: req_valid  in  1  initiator presents a request.
REQ-006 SHALL have: req_ready  out  1  responder can accept; transfer occurs on a rising edge with req_valid & req_ready.
REQ-007 SHALL have: req_wr  in  1  1 = write, 0 = read.
REQ-008 SHALL have: req_burst  in  1  1 = 8-beat line read (ignored when req_wr=1).
REQ-009 SHALL have: req_addr  in  16  byte address; bit 0 ignored (word access).
REQ-010 SHALL have: req_wdata  in  16  write data.
REQ-011 SHALL have: rsp_valid  out  1  read data beat valid (no back-pressure).
REQ-012 SHALL have: rsp_data  out  16  read data beat.
REQ-013 SHALL have: rsp_addr  out  16  byte address of the returned word (bit 0 = 0).
REQ-014 SHALL have: rsp_last  out  1  final beat of the read (single read or burst beat 7).

Function
REQ-015 Word index SHALL be req_addr[DEPTH_LOG2:1]; upper address bits are ignored (aliasing).
REQ-016 Write: storage updated at the acceptance edge; no response generated.
REQ-017 Single read: storage read at acceptance edge; one beat with rsp_last=1 presented exactly LATENCY cycles after the acceptance cycle.
REQ-018 Reads SHALL be pipelined: one new read accepted per cycle, up to LATENCY in flight, responses in acceptance order, one cycle each.
REQ-019 Burst read: base = {req_addr[15:4], 4'h0}; beats k=0..7 read word base+2k, internal read for beat k at acceptance cycle + k.
REQ-020 Burst beat k SHALL appear on rsp_* at acceptance cycle + LATENCY + k; rsp_last=1 only on k=7; rsp_addr=base+2k.
REQ-021 FSM states: IDLE, BURST. IDLE->BURST on accepted burst read (beat counter := 1); BURST increments counter each cycle; BURST->IDLE after beat 7 issued.
REQ-022 req_ready SHALL be 1 in IDLE and 0 in BURST (7 cycles after burst acceptance); 0 while rst=1.
REQ-023 Read issued in the cycle after a write to the same word SHALL return the written data; read and write never accepted in the same cycle (one request per cycle).
REQ-024 Burst addresses wrap within the aligned 16-byte line only; no carry into bit 4.
REQ-025 When rsp_valid=0, rsp_data, rsp_addr and rsp_last SHALL be 0.
REQ-026 req_valid while req_ready=0 SHALL be ignored; the initiator holds the request.

Reset
REQ-027 On rst=1 at a clock edge: FSM := IDLE, beat counter := 0, all latency-pipeline valid bits := 0; rsp_valid, rsp_last := 0, rsp_data, rsp_addr := 0.
REQ-028 Storage contents SHALL NOT be cleared by reset.
REQ-029 Reset mid-burst or with reads in flight SHALL drop all pending beats; no rsp_valid in any cycle after the reset edge until a new read is accepted.
REQ-030 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-031 Write 0x1234 to 0x0010, next cycle single read 0x0010 -> rsp_valid=1, rsp_data=0x1234, rsp_addr=0x0010, rsp_last=1 exactly 4 cycles after read acceptance.
REQ-032 Back-to-back single reads of 0x0000, 0x0002, 0x0004 (preloaded 0xA, 0xB, 0xC) on cycles T..T+2 -> beats 0xA, 0xB, 0xC on cycles T+4..T+6, rsp_last=1 on each.
REQ-033 Burst read at 0x0046 with words 0x0040..0x004E preloaded 0x100..0x107 -> req_ready=0 for 7 cycles; beats 0x100..0x107 at T+4..T+11, rsp_addr 0x0040..0x004E, rsp_last only at T+11.
REQ-034 Request held with req_valid=1 during BURST -> not accepted until req_ready returns to 1, then serviced normally.
REQ-035 Assert rst for one cycle at T+6 of a burst -> no rsp_valid after the reset edge; req_ready=1 next cycle; earlier-written data still readable.
REQ-036 Write to 0x0002 and read of 0x10002 (DEPTH_LOG2=15) -> read returns aliased written value.
